// File: rtl/reu_dma_seq.sv
// REU DMA sequencer: paces stash/fetch/swap/verify transfers on PHI2 slots and
// drives the SDRAM controller commands plus the C64 bus read/write strobes.
module reu_dma_seq #(
  parameter int REU_AW = 24
) (
  input  logic              C8M,
  input  logic              nRESET,
  input  logic              PHI2,
  input  logic              START,
  input  logic [1:0]        MODE,
  input  logic              AUTOLOAD,
  input  logic              FIXC64,
  input  logic              FIXREU,
  input  logic [15:0]       BASEC64,
  input  logic [REU_AW-1:0] BASEREU,
  input  logic [15:0]       BASELEN,
  input  logic [7:0]        C64D,
  input  logic [7:0]        RDD,
  output logic              RDCMD,
  output logic              WRCMD,
  output logic [REU_AW-1:0] A,
  output logic [15:0]       C64A,
  output logic [15:0]       CURLEN,
  output logic              DMA,
  output logic              C64RD,
  output logic              C64WR,
  output logic              BUSY,
  output logic              DONE,
  output logic              VERR
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_SLOT, S_FIN} state_t;
  typedef enum logic [1:0] {M_STASH, M_FETCH, M_SWAP, M_VERIFY} mode_t;
  typedef struct packed {
    logic rd;
    logic wr;
    logic c64rd;
    logic c64wr;
  } cmd_t;

  // Command set driven during a given phase of one byte.
  function automatic cmd_t phase_cmd(mode_t m, logic [1:0] p);
    cmd_t c;
    c = '0;
    case (m)
      M_STASH:  begin c.c64rd = 1'b1; c.wr = 1'b1; end
      M_FETCH:  if (p == 2'd0) c.rd = 1'b1; else c.c64wr = 1'b1;
      M_SWAP: begin
        if (p == 2'd0)      c.rd = 1'b1;
        else if (p == 2'd1) begin c.c64rd = 1'b1; c.wr = 1'b1; end
        else                c.c64wr = 1'b1;
      end
      M_VERIFY: if (p == 2'd0) c.rd = 1'b1; else c.c64rd = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] last_phase(mode_t m);
    case (m)
      M_STASH: return 2'd0;
      M_SWAP:  return 2'd2;
      default: return 2'd1;
    endcase
  endfunction

  // PHI2 crosses into the C8M domain through two flops; a third holds history.
  logic phi_s1, phi_s2, phi_prev;
  logic rise, fall;

  always_ff @(posedge C8M or negedge nRESET) begin
    if (!nRESET) begin
      phi_s1   <= 1'b0;
      phi_s2   <= 1'b0;
      phi_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value,
      // which is what turns these three lines into a shift register.
      phi_s1   <= PHI2;
      phi_s2   <= phi_s1;
      phi_prev <= phi_s2;
    end
  end

  assign rise = phi_s2 & ~phi_prev;
  assign fall = ~phi_s2 & phi_prev;

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [1:0]        phase_q, phase_d;
  logic              arm_q, arm_d;
  logic              fixc_q, fixc_d, fixr_q, fixr_d, auto_q, auto_d;
  logic [REU_AW-1:0] a_q, a_d;
  logic [15:0]       c_q, c_d, len_q, len_d;
  cmd_t              cmd_q, cmd_d;
  logic              verr_q, verr_d, mism_q, mism_d;
  logic              live_q, live_d;

  always_ff @(posedge C8M or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= S_IDLE;
      mode_q  <= M_STASH;
      phase_q <= 2'd0;
      arm_q   <= 1'b0;
      fixc_q  <= 1'b0;
      fixr_q  <= 1'b0;
      auto_q  <= 1'b0;
      a_q     <= '0;
      c_q     <= '0;
      len_q   <= '0;
      cmd_q   <= '0;
      verr_q  <= 1'b0;
      mism_q  <= 1'b0;
      live_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      arm_q   <= arm_d;
      fixc_q  <= fixc_d;
      fixr_q  <= fixr_d;
      auto_q  <= auto_d;
      a_q     <= a_d;
      c_q     <= c_d;
      len_q   <= len_d;
      cmd_q   <= cmd_d;
      verr_q  <= verr_d;
      mism_q  <= mism_d;
      live_q  <= live_d;
    end
  end

  always_comb begin
    // NOTE: every next-state variable starts from its held value so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d = state_q;
    mode_d  = mode_q;
    phase_d = phase_q;
    arm_d   = arm_q;
    fixc_d  = fixc_q;
    fixr_d  = fixr_q;
    auto_d  = auto_q;
    a_d     = a_q;
    c_d     = c_q;
    len_d   = len_q;
    cmd_d   = cmd_q;
    verr_d  = verr_q;
    mism_d  = mism_q;
    live_d  = live_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_ARM;
          mode_d  = mode_t'(MODE);
          fixc_d  = FIXC64;
          fixr_d  = FIXREU;
          auto_d  = AUTOLOAD;
          a_d     = BASEREU;
          c_d     = BASEC64;
          len_d   = BASELEN;
          arm_d   = 1'b0;
          cmd_d   = '0;
          verr_d  = 1'b0;
          mism_d  = 1'b0;
          live_d  = 1'b0;
        end
      end
      S_ARM: begin
        if (rise) begin
          if (arm_q) begin
            state_d = S_SLOT;
            phase_d = 2'd0;
            cmd_d   = phase_cmd(mode_q, 2'd0);
          end else begin
            arm_d = 1'b1;
          end
        end
      end
      S_SLOT: begin
        if (fall && mode_q == M_VERIFY && phase_q == 2'd1 && C64D != RDD) begin
          verr_d = 1'b1;
          mism_d = 1'b1;
        end
        if (rise) begin
          if (mism_q) begin
            // Pointers stay on the failing byte.
            state_d = S_FIN;
            cmd_d   = '0;
          end else if (phase_q == last_phase(mode_q)) begin
            if (!fixc_q) c_d = c_q + 16'd1;
            if (!fixr_q) a_d = a_q + REU_AW'(1);
            if (len_q == 16'd1) begin
              state_d = S_FIN;
              cmd_d   = '0;
            end else begin
              len_d   = len_q - 16'd1;
              phase_d = 2'd0;
              cmd_d   = phase_cmd(mode_q, 2'd0);
            end
          end else begin
            phase_d = phase_q + 2'd1;
            cmd_d   = phase_cmd(mode_q, phase_q + 2'd1);
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        cmd_d   = '0;
        if (auto_q) live_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // While idle after reset or an autoload, the base registers show through live.
  assign A      = live_q ? BASEREU : a_q;
  assign C64A   = live_q ? BASEC64 : c_q;
  assign CURLEN = live_q ? BASELEN : len_q;

  assign RDCMD = cmd_q.rd;
  assign WRCMD = cmd_q.wr;
  assign C64RD = cmd_q.c64rd;
  assign C64WR = cmd_q.c64wr;
  assign BUSY  = (state_q == S_ARM) || (state_q == S_SLOT);
  assign DMA   = BUSY;
  assign DONE  = (state_q == S_FIN);
  assign VERR  = verr_q;

endmodule

// File: tb/tb_reu_dma_seq.sv
// Scoreboard bench for reu_dma_seq: a transfer-level model predicts every bus
// slot and the end-of-transfer state; monitors compare what the DUT presents.
module tb_reu_dma_seq;
  localparam int AW = 24;

  logic          C8M = 1'b0, nRESET = 1'b0, PHI2 = 1'b0, START = 1'b0;
  logic [1:0]    MODE = 2'd0;
  logic          AUTOLOAD = 1'b0, FIXC64 = 1'b0, FIXREU = 1'b0;
  logic [15:0]   BASEC64 = 16'h0, BASELEN = 16'h1;
  logic [AW-1:0] BASEREU = '0;
  logic [7:0]    C64D;
  logic [7:0]    RDD = 8'h0;
  logic          RDCMD, WRCMD, DMA, C64RD, C64WR, BUSY, DONE, VERR;
  logic [AW-1:0] A;
  logic [15:0]   C64A, CURLEN;

  reu_dma_seq #(.REU_AW(AW)) dut (
    .C8M(C8M), .nRESET(nRESET), .PHI2(PHI2), .START(START), .MODE(MODE),
    .AUTOLOAD(AUTOLOAD), .FIXC64(FIXC64), .FIXREU(FIXREU), .BASEC64(BASEC64),
    .BASEREU(BASEREU), .BASELEN(BASELEN), .C64D(C64D), .RDD(RDD),
    .RDCMD(RDCMD), .WRCMD(WRCMD), .A(A), .C64A(C64A), .CURLEN(CURLEN),
    .DMA(DMA), .C64RD(C64RD), .C64WR(C64WR), .BUSY(BUSY), .DONE(DONE), .VERR(VERR)
  );

  always #5 C8M = ~C8M;
  initial begin
    #3;
    forever #40 PHI2 = ~PHI2;
  end

  typedef struct {
    logic [3:0]    cmd;   // {RDCMD, WRCMD, C64RD, C64WR}
    logic [AW-1:0] a;
    logic [15:0]   c;
    logic          chk;
    logic [7:0]    d;
  } slot_t;
  typedef struct {
    logic          verr;
    logic [AW-1:0] a;
    logic [15:0]   c;
    logic [15:0]   len;
  } end_t;

  slot_t slot_q[$];
  end_t  end_q[$];
  int errors = 0, checks = 0;
  int ends_seen = 0, slots_seen = 0, dma_falls = 0;

  // Bus-side memories (driven by the environment) and the model's own copies.
  logic [7:0] reu_mem [logic [AW-1:0]];
  logic [7:0] ref_reu [logic [AW-1:0]];
  logic [7:0] c64_mem [0:65535];
  logic [7:0] ref_c64 [0:65535];

  function automatic logic [7:0] init8(logic [AW-1:0] k);
    return k[7:0] ^ k[15:8] ^ k[23:16] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] reu_get(logic [AW-1:0] k);
    return reu_mem.exists(k) ? reu_mem[k] : init8(k);
  endfunction
  function automatic logic [7:0] ref_get(logic [AW-1:0] k);
    return ref_reu.exists(k) ? ref_reu[k] : init8(k);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  assign C64D = c64_mem[C64A];

  // SDRAM controller: RDD follows reads only.
  initial forever begin
    @(posedge C8M);
    #1;
    if (nRESET && RDCMD) RDD = reu_get(A);
  end

  // Write data is taken at the PHI2 fall.
  initial forever begin
    @(negedge PHI2);
    #1;
    if (nRESET) begin
      if (WRCMD) reu_mem[A] = C64D;
      if (C64WR) c64_mem[C64A] = RDD;
    end
  end

  // Slot monitor: one sample per slot, at the PHI2 fall.
  always @(negedge PHI2) begin
    slot_t s;
    if (nRESET && DMA) dma_falls++;
    if (nRESET && (RDCMD | WRCMD | C64RD | C64WR)) begin
      slots_seen++;
      if (slot_q.size() == 0) begin
        check("unexpected_slot", {RDCMD, WRCMD, C64RD, C64WR}, 64'd0);
      end else begin
        s = slot_q.pop_front();
        check("slot", {RDCMD, WRCMD, C64RD, C64WR, A, C64A}, {s.cmd, s.a, s.c});
        check("slot_busy", {BUSY, DMA}, 2'b11);
        if (s.chk) check("slot_data", RDD, s.d);
      end
    end
  end

  // Completion monitor: end state is compared on the cycle after DONE.
  bit done_pend = 0;
  always @(negedge C8M) begin
    end_t e;
    if (done_pend) begin
      done_pend = 0;
      e = end_q.pop_front();
      check("end_state", {VERR, A, C64A, CURLEN}, {e.verr, e.a, e.c, e.len});
      check("end_idle", {BUSY, DMA, DONE}, 3'b000);
      ends_seen++;
    end
    if (nRESET && DONE) begin
      if (end_q.size() == 0) check("unexpected_done", DONE, 1'b0);
      else done_pend = 1;
    end
  end

  function automatic void push_slot(logic [3:0] cmd, logic [AW-1:0] a, logic [15:0] c,
                                    logic chk, logic [7:0] d);
    slot_t s;
    s.cmd = cmd; s.a = a; s.c = c; s.chk = chk; s.d = d;
    slot_q.push_back(s);
  endfunction

  function automatic void push_end(logic v, logic [AW-1:0] a, logic [15:0] c, logic [15:0] l);
    end_t e;
    e.verr = v; e.a = a; e.c = c; e.len = l;
    end_q.push_back(e);
  endfunction

  // Transfer-level reference: walks the bytes and applies each mode's effect.
  task automatic model(input logic [1:0] m, input logic [15:0] bc, input logic [AW-1:0] br,
                       input logic [15:0] len, input logic al, input logic fc, input logic fr,
                       input int maxb, input bit want_end);
    int n, lim;
    logic [AW-1:0] a;
    logic [15:0] c;
    logic [7:0] t;
    n   = (len == 16'd0) ? 65536 : int'(len);
    lim = (n < maxb) ? n : maxb;
    for (int i = 0; i < lim; i++) begin
      a = br + (fr ? '0 : AW'(i));
      c = bc + (fc ? 16'd0 : 16'(i));
      t = ref_get(a);
      case (m)
        2'd0: begin
          push_slot(4'b0110, a, c, 1'b0, 8'h0);
          ref_reu[a] = ref_c64[c];
        end
        2'd1: begin
          push_slot(4'b1000, a, c, 1'b0, 8'h0);
          push_slot(4'b0001, a, c, 1'b1, t);
          ref_c64[c] = t;
        end
        2'd2: begin
          push_slot(4'b1000, a, c, 1'b0, 8'h0);
          push_slot(4'b0110, a, c, 1'b0, 8'h0);
          push_slot(4'b0001, a, c, 1'b1, t);
          ref_reu[a] = ref_c64[c];
          ref_c64[c] = t;
        end
        default: begin
          push_slot(4'b1000, a, c, 1'b0, 8'h0);
          push_slot(4'b0010, a, c, 1'b0, 8'h0);
          if (ref_c64[c] != t) begin
            if (want_end) push_end(1'b1, al ? br : a, al ? bc : c, al ? len : 16'(n - i));
            return;
          end
        end
      endcase
    end
    if (want_end) begin
      if (al) push_end(1'b0, br, bc, len);
      else push_end(1'b0, br + (fr ? '0 : AW'(n)), bc + (fc ? 16'd0 : 16'(n)), 16'd1);
    end
  endtask

  task automatic setup(input logic [1:0] m, input logic [15:0] bc, input logic [AW-1:0] br,
                       input logic [15:0] len, input logic al, input logic fc, input logic fr);
    @(negedge C8M);
    MODE = m; BASEC64 = bc; BASEREU = br; BASELEN = len;
    AUTOLOAD = al; FIXC64 = fc; FIXREU = fr;
  endtask

  task automatic pulse_start();
    @(negedge PHI2);
    repeat (2) @(negedge C8M);
    START = 1'b1;
    @(negedge C8M);
    START = 1'b0;
  endtask

  task automatic wait_end(input int target);
    int n;
    n = 0;
    while (ends_seen < target && n < 20000) begin
      @(negedge C8M);
      n++;
    end
    check("end_reached", ends_seen, target);
    check("slots_left", slot_q.size(), 0);
  endtask

  task automatic run(input logic [1:0] m, input logic [15:0] bc, input logic [AW-1:0] br,
                     input logic [15:0] len, input logic al, input logic fc, input logic fr);
    int target;
    target = ends_seen + 1;
    setup(m, bc, br, len, al, fc, fr);
    model(m, bc, br, len, al, fc, fr, 70000, 1'b1);
    pulse_start();
    wait_end(target);
  endtask

  initial begin
    int n, target;
    for (int i = 0; i < 65536; i++) begin
      c64_mem[i] = init8(AW'(i)) ^ 8'h3C;
      ref_c64[i] = c64_mem[i];
    end

    // Reset: controls low, pointers follow the base inputs live.
    BASEREU = 24'h123456; BASEC64 = 16'hBEEF; BASELEN = 16'h0042;
    #23;
    check("reset_ctrl", {BUSY, DMA, DONE, RDCMD, WRCMD, C64RD, C64WR, VERR}, 8'h00);
    check("reset_live", {A, C64A, CURLEN}, {24'h123456, 16'hBEEF, 16'h0042});
    BASEREU = 24'h00ABCD;
    #1;
    check("reset_live_follow", A, 24'h00ABCD);
    @(negedge C8M);
    nRESET = 1'b1;

    // Stash, 3 bytes.
    run(2'd0, 16'h1000, 24'h000200, 16'd3, 1'b0, 1'b0, 1'b0);
    // Fetch with fixed C64 pointer.
    run(2'd1, 16'h2000, 24'h000300, 16'd2, 1'b0, 1'b1, 1'b0);
    // Swap, one byte: ARM slot plus three byte slots under DMA.
    dma_falls = 0;
    run(2'd2, 16'h3000, 24'h000400, 16'd1, 1'b0, 1'b0, 1'b0);
    check("swap_dma_slots", dma_falls, 4);

    // Verify with a mismatch on the second byte.
    c64_mem[16'h4000] = 8'h11; ref_c64[16'h4000] = 8'h11;
    reu_mem[24'h000500] = 8'h11; ref_reu[24'h000500] = 8'h11;
    c64_mem[16'h4001] = 8'h22; ref_c64[16'h4001] = 8'h22;
    reu_mem[24'h000501] = 8'h23; ref_reu[24'h000501] = 8'h23;
    run(2'd3, 16'h4000, 24'h000500, 16'd4, 1'b0, 1'b0, 1'b0);

    // Wrap at the top of REU space, aborted by reset after two bytes.
    setup(2'd0, 16'h5000, 24'hFFFFFF, 16'd0, 1'b1, 1'b0, 1'b0);
    model(2'd0, 16'h5000, 24'hFFFFFF, 16'd0, 1'b1, 1'b0, 1'b0, 2, 1'b0);
    target = ends_seen;
    pulse_start();
    n = 0;
    while (slot_q.size() != 0 && n < 5000) begin
      @(negedge C8M);
      n++;
    end
    check("wrap_slots_seen", slot_q.size(), 0);
    #2 nRESET = 1'b0;
    #1;
    check("abort_ctrl", {BUSY, DMA, DONE, RDCMD, WRCMD, C64RD, C64WR, VERR}, 8'h00);
    check("abort_live", {A, C64A, CURLEN}, {24'hFFFFFF, 16'h5000, 16'h0000});
    repeat (20) @(negedge C8M);
    check("abort_no_done", ends_seen, target);
    nRESET = 1'b1;

    // START while busy is ignored; autoload restores the bases.
    target = ends_seen + 1;
    setup(2'd1, 16'h6000, 24'h000700, 16'd2, 1'b1, 1'b0, 1'b0);
    model(2'd1, 16'h6000, 24'h000700, 16'd2, 1'b1, 1'b0, 1'b0, 70000, 1'b1);
    pulse_start();
    repeat (20) @(negedge C8M);
    MODE = 2'd0;
    START = 1'b1;
    @(negedge C8M);
    START = 1'b0;
    MODE = 2'd1;
    wait_end(target);

    // Randomised transfers.
    for (int k = 0; k < 10; k++) begin
      run(2'($urandom_range(0, 3)), 16'($urandom), AW'($urandom),
          16'($urandom_range(1, 4)), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
